i2c_req_arbiter: RTL and testbench

Shares one byte-level I2C master engine among NUM_REQ requesters using round-robin arbitration. Each requester posts a single-byte transaction: 7-bit address, direction, and write data. The arbiter grants one requester, launches the engine, waits for completion, returns read data and NACK/timeout status, then releases the grant. It sits between the fabric-side clients (sensor pollers, config loaders) and the I2C master engine that drives the bus.

---
 rtl/i2c_req_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master engine among NUM_REQ requesters.
// Optional watchdog on the engine busy window: define I2C_ARB_TIMEOUT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no grant; pick next requester when engine is free
// S_LAUNCH    | grant and m_* latched, m_start high this cycle
// S_WAIT_BUSY | waiting for the engine to raise m_busy
// S_WAIT_DONE | engine running, waiting for m_busy to fall
// S_COMPLETE  | done pulse to granted requester, grant released on exit

module i2c_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic                 m_rw,
    output logic [7:0]           m_wdata,
    input  logic                 m_busy,
    input  logic [7:0]           m_rdata,
    input  logic                 m_nack
);

    localparam int                 SW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SW:0]        NUM_REQ_W = (SW+1)'(NUM_REQ);
    localparam logic [SW-1:0]      LAST_RST  = SW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_COMPLETE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SW-1:0]      r_sel;
    logic [SW-1:0]      r_last;
    logic [SW-1:0]      w_sel;
    logic               w_found;
    logic               w_launch;
    logic               w_finish;
    logic               w_tmo_fire;
    logic               w_tmo_hit;

    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [7:0]         r_rdata;
    logic               r_err;
    logic               r_start;
    logic [6:0]         r_addr;
    logic               r_rw;
    logic [7:0]         r_wdata;

    logic [6:0]         w_addr_a  [NUM_REQ];
    logic [7:0]         w_wdata_a [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign w_addr_a[gi]  = req_addr[7*gi +: 7];
            assign w_wdata_a[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

    // Scan from last+1 so the most recently served slot is considered last.
    always_comb begin
        logic [SW:0] v_idx;
        w_found = 1'b0;
        w_sel   = '0;
        v_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = {1'b0, r_last} + (SW+1)'(k);
            if (v_idx >= NUM_REQ_W) begin
                v_idx = v_idx - NUM_REQ_W;
            end
            if (!w_found && req[v_idx[SW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = v_idx[SW-1:0];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic [15:0] w_tmo_inc;

    assign w_tmo_inc = r_tmo_cnt + 16'd1;
    // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
    assign w_tmo_hit = (w_tmo_inc == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || r_state == S_LAUNCH) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
            r_tmo_cnt <= w_tmo_inc;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_launch   = 1'b0;
        w_finish   = 1'b0;
        w_tmo_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!m_busy && w_found) begin
                    w_launch = 1'b1;
                    w_next   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (w_tmo_hit) begin
                    w_tmo_fire = 1'b1;
                    w_next     = S_COMPLETE;
                end else if (m_busy) begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A real completion wins over a watchdog expiring the same cycle.
                if (!m_busy) begin
                    w_finish = 1'b1;
                    w_next   = S_COMPLETE;
                end else if (w_tmo_hit) begin
                    w_tmo_fire = 1'b1;
                    w_next     = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= '0;
            r_last  <= LAST_RST;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_start <= w_launch;

            if (w_launch) begin
                r_sel   <= w_sel;
                r_gnt   <= ONE_HOT0 << w_sel;
                r_addr  <= w_addr_a[w_sel];
                r_rw    <= req_rw[w_sel];
                r_wdata <= w_wdata_a[w_sel];
            end else if (r_state == S_COMPLETE) begin
                r_gnt  <= '0;
                r_last <= r_sel;
            end

            if (w_finish) begin
                r_done  <= ONE_HOT0 << r_sel;
                r_rdata <= r_rw ? m_rdata : 8'h00;
                r_err   <= m_nack;
            end else if (w_tmo_fire) begin
                r_done  <= ONE_HOT0 << r_sel;
                r_rdata <= 8'h00;
                r_err   <= 1'b1;
            end else begin
                r_done <= '0;
            end
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign err     = r_err;
    assign m_start = r_start;
    assign m_addr  = r_addr;
    assign m_rw    = r_rw;
    assign m_wdata = r_wdata;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: vector table plus hand sequences for
// busy gating, in-flight input changes, reset abort, contention and timeout.

module tb_i2c_req_arbiter;

    localparam int TMO = 50;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [13:0] req_addr;
    logic [1:0]  req_rw;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rdata;
    logic        err;
    logic        m_start;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_wdata;
    logic        m_busy;
    logic [7:0]  m_rdata = 8'h00;
    logic        m_nack  = 1'b0;

    i2c_req_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_rw      (m_rw),
        .m_wdata   (m_wdata),
        .m_busy    (m_busy),
        .m_rdata   (m_rdata),
        .m_nack    (m_nack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: registers m_start, then holds busy for eng_lat cycles.
    logic       eng_rst    = 1'b1;
    logic       eng_stuck  = 1'b0;
    logic       force_busy = 1'b0;
    int         eng_lat    = 2;
    logic [7:0] eng_rd     = 8'h00;
    logic       eng_nack   = 1'b0;
    logic       eng_busy   = 1'b0;
    logic       pend_start = 1'b0;
    int         eng_cnt    = 0;

    assign m_busy = eng_busy | force_busy;

    always begin
        @(posedge clk);
        #1;
        if (eng_rst) begin
            eng_busy   = 1'b0;
            eng_cnt    = 0;
            pend_start = 1'b0;
        end else begin
            if (eng_cnt > 0) begin
                if (!eng_stuck) begin
                    eng_cnt = eng_cnt - 1;
                    if (eng_cnt == 0) begin
                        eng_busy = 1'b0;
                        m_rdata  = eng_rd;
                        m_nack   = eng_nack;
                    end
                end
            end else if (pend_start) begin
                eng_busy = 1'b1;
                eng_cnt  = eng_lat;
                m_rdata  = 8'hEE;
                m_nack   = ~eng_nack;
            end
            pend_start = m_start;
        end
    end

    int         ncmp = 0;
    int         nfail = 0;
    int         starts = 0;
    int         dones = 0;
    int         stray = 0;
    int         launch_cyc = 0;
    int         done_cyc = 0;
    int         req_cyc = 0;
    logic [1:0] allow = 2'b00;
    logic [1:0] last_done = 2'b00;
    logic [1:0] cap_gnt = 2'b00;
    logic [6:0] cap_addr = 7'h00;
    logic       cap_rw = 1'b0;
    logic [7:0] cap_wdata = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_start) begin
            starts++;
            launch_cyc = cyc;
            cap_gnt    = gnt;
            cap_addr   = m_addr;
            cap_rw     = m_rw;
            cap_wdata  = m_wdata;
        end
        if (done != 2'b00) begin
            dones++;
            last_done = done;
            done_cyc  = cyc;
        end
        if ((gnt & ~allow) != 2'b00) stray++;
    endtask

    task automatic wait_done(input int limit);
        int n;
        int d0;
        n  = 0;
        d0 = dones;
        while (dones == d0 && n < limit) begin
            tick();
            n++;
        end
        if (dones == d0) begin
            ncmp++;
            nfail++;
            $display("FAIL wait_done: no done pulse within %0d cycles", limit);
        end
    endtask

    task automatic wait_start(input int limit);
        int n;
        int s0;
        n  = 0;
        s0 = starts;
        while (starts == s0 && n < limit) begin
            tick();
            n++;
        end
        if (starts == s0) begin
            ncmp++;
            nfail++;
            $display("FAIL wait_start: no m_start within %0d cycles", limit);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [13:0] addr;
        logic [1:0]  rw;
        logic [15:0] wdata;
        int          lat;
        logic [7:0]  erd;
        logic        enack;
        logic [1:0]  x_done;
        logic [6:0]  x_addr;
        logic        x_rw;
        logic [7:0]  x_wdata;
        logic [7:0]  x_rdata;
        logic        x_err;
    } vec_t;

    vec_t vt [7];

    initial begin
        // addr = {slot1, slot0}; wdata = {slot1, slot0}
        vt[0] = '{2'b01, {7'h00, 7'h2A}, 2'b00, {8'h00, 8'h5C}, 20, 8'h33, 1'b0, 2'b01, 7'h2A, 1'b0, 8'h5C, 8'h00, 1'b0};
        vt[1] = '{2'b10, {7'h11, 7'h2A}, 2'b10, {8'h99, 8'h5C},  5, 8'hA7, 1'b0, 2'b10, 7'h11, 1'b1, 8'h99, 8'hA7, 1'b0};
        vt[2] = '{2'b01, {7'h11, 7'h50}, 2'b01, {8'h99, 8'h3C},  3, 8'hFF, 1'b1, 2'b01, 7'h50, 1'b1, 8'h3C, 8'hFF, 1'b1};
        vt[3] = '{2'b10, {7'h7F, 7'h50}, 2'b00, {8'hA5, 8'h3C},  1, 8'h12, 1'b0, 2'b10, 7'h7F, 1'b0, 8'hA5, 8'h00, 1'b0};
        vt[4] = '{2'b01, {7'h7F, 7'h00}, 2'b00, {8'hA5, 8'hFF},  4, 8'h77, 1'b1, 2'b01, 7'h00, 1'b0, 8'hFF, 8'h00, 1'b1};
        vt[5] = '{2'b11, {7'h02, 7'h01}, 2'b10, {8'h20, 8'h10},  6, 8'h6B, 1'b0, 2'b10, 7'h02, 1'b1, 8'h20, 8'h6B, 1'b0};
        vt[6] = '{2'b11, {7'h02, 7'h01}, 2'b10, {8'h20, 8'h10},  6, 8'h6B, 1'b0, 2'b01, 7'h01, 1'b0, 8'h10, 8'h00, 1'b0};

        rst       = 1'b1;
        req       = 2'b00;
        req_addr  = '0;
        req_rw    = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_gnt",     gnt,     2'b00);
        check("rst_done",    done,    2'b00);
        check("rst_rdata",   rdata,   8'h00);
        check("rst_err",     err,     1'b0);
        check("rst_m_start", m_start, 1'b0);
        check("rst_m_addr",  m_addr,  7'h00);
        check("rst_m_rw",    m_rw,    1'b0);
        check("rst_m_wdata", m_wdata, 8'h00);

        rst     = 1'b0;
        eng_rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            req_addr  = vt[i].addr;
            req_rw    = vt[i].rw;
            req_wdata = vt[i].wdata;
            eng_lat   = vt[i].lat;
            eng_rd    = vt[i].erd;
            eng_nack  = vt[i].enack;
            allow     = vt[i].x_done;
            starts    = 0;
            stray     = 0;
            req_cyc   = cyc;
            req       = vt[i].req;
            wait_done(200);
            req = 2'b00;
            check($sformatf("v%0d_done", i),      last_done, vt[i].x_done);
            check($sformatf("v%0d_starts", i),    starts,    1);
            check($sformatf("v%0d_gnt", i),       cap_gnt,   vt[i].x_done);
            check($sformatf("v%0d_m_addr", i),    cap_addr,  vt[i].x_addr);
            check($sformatf("v%0d_m_rw", i),      cap_rw,    vt[i].x_rw);
            check($sformatf("v%0d_m_wdata", i),   cap_wdata, vt[i].x_wdata);
            check($sformatf("v%0d_rdata", i),     rdata,     vt[i].x_rdata);
            check($sformatf("v%0d_err", i),       err,       vt[i].x_err);
            check($sformatf("v%0d_stray", i),     stray,     0);
            check($sformatf("v%0d_start_lat", i), launch_cyc - req_cyc, 1);
            check($sformatf("v%0d_done_lat", i),  done_cyc - launch_cyc, vt[i].lat + 2);
            tick();
            check($sformatf("v%0d_done_clr", i),  done, 2'b00);
            check($sformatf("v%0d_gnt_clr", i),   gnt,  2'b00);
        end

        // Granted inputs change and req drops mid-flight; transaction unaffected.
        req_addr  = {7'h00, 7'h33};
        req_wdata = {8'h00, 8'h44};
        req_rw    = 2'b00;
        eng_lat   = 8;
        eng_rd    = 8'h5A;
        eng_nack  = 1'b0;
        allow     = 2'b01;
        req       = 2'b01;
        wait_start(10);
        req_addr[6:0]  = 7'h55;
        req_wdata[7:0] = 8'h66;
        req_rw[0]      = 1'b1;
        req            = 2'b00;
        wait_done(100);
        check("chg_done",    last_done, 2'b01);
        check("chg_m_addr",  m_addr,    7'h33);
        check("chg_m_wdata", m_wdata,   8'h44);
        check("chg_m_rw",    m_rw,      1'b0);
        check("chg_rdata",   rdata,     8'h00);
        tick();

        // Engine busy in IDLE blocks any launch.
        force_busy = 1'b1;
        req_addr   = {7'h00, 7'h21};
        req_rw     = 2'b01;
        eng_lat    = 3;
        eng_rd     = 8'hC3;
        eng_nack   = 1'b1;
        starts     = 0;
        req        = 2'b01;
        repeat (10) tick();
        check("gate_starts", starts, 0);
        check("gate_gnt",    gnt,    2'b00);
        force_busy = 1'b0;
        wait_done(100);
        req = 2'b00;
        check("gate_done",  last_done, 2'b01);
        check("gate_rdata", rdata,     8'hC3);
        check("gate_err",   err,       1'b1);
        tick();

        // Reset during WAIT_DONE aborts the transaction of requester 1.
        req_addr = {7'h4D, 7'h21};
        req_rw   = 2'b10;
        eng_lat  = 30;
        eng_nack = 1'b0;
        allow    = 2'b10;
        req      = 2'b10;
        wait_start(10);
        repeat (5) tick();
        begin
            int d0;
            d0      = dones;
            rst     = 1'b1;
            eng_rst = 1'b1;
            req     = 2'b00;
            tick();
            check("abort_gnt",     gnt,     2'b00);
            check("abort_done",    done,    2'b00);
            check("abort_m_start", m_start, 1'b0);
            check("abort_m_addr",  m_addr,  7'h00);
            check("abort_m_rw",    m_rw,    1'b0);
            check("abort_rdata",   rdata,   8'h00);
            check("abort_err",     err,     1'b0);
            rst     = 1'b0;
            eng_rst = 1'b0;
            repeat (5) tick();
            check("abort_no_done", dones - d0, 0);
        end

        // Continuous contention: strict alternation, requester 0 first after reset.
        req_addr  = {7'h20, 7'h10};
        req_rw    = 2'b00;
        req_wdata = {8'hB2, 8'hB1};
        eng_lat   = 2;
        allow     = 2'b11;
        req       = 2'b11;
        begin
            int prev_done;
            logic [1:0] exp_d;
            prev_done = 0;
            for (int k = 0; k < 4; k++) begin
                exp_d = (k % 2 == 0) ? 2'b01 : 2'b10;
                wait_done(100);
                if (k == 3) req = 2'b00;
                check($sformatf("rr%0d_done", k), last_done, exp_d);
                check($sformatf("rr%0d_gnt", k),  cap_gnt,   exp_d);
                check($sformatf("rr%0d_addr", k), cap_addr,  (exp_d == 2'b01) ? 7'h10 : 7'h20);
                if (k > 0) check($sformatf("rr%0d_b2b", k), launch_cyc - prev_done, 2);
                prev_done = done_cyc;
                tick();
                check($sformatf("rr%0d_idle_gnt", k),   gnt,     2'b00);
                check($sformatf("rr%0d_idle_start", k), m_start, 1'b0);
            end
        end

`ifdef I2C_ARB_TIMEOUT_EN
        // Stuck engine: 50 wait cycles after LAUNCH, then COMPLETE with err.
        eng_stuck = 1'b1;
        eng_lat   = 5;
        eng_rd    = 8'h99;
        req_rw    = 2'b01;
        allow     = 2'b01;
        req       = 2'b01;
        wait_done(200);
        check("tmo_done",  last_done, 2'b01);
        check("tmo_err",   err,       1'b1);
        check("tmo_rdata", rdata,     8'h00);
        check("tmo_lat",   done_cyc - launch_cyc, TMO + 1);
        starts = 0;
        repeat (20) tick();
        check("tmo_no_start", starts, 0);
        check("tmo_no_gnt",   gnt,    2'b00);
        req       = 2'b00;
        eng_rst   = 1'b1;
        tick();
        eng_rst   = 1'b0;
        eng_stuck = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
